// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and decode helpers for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] FUNCT3_MEM_B  = 3'b000;
  localparam logic [2:0] FUNCT3_MEM_H  = 3'b001;
  localparam logic [2:0] FUNCT3_MEM_W  = 3'b010;
  localparam logic [2:0] FUNCT3_MEM_BU = 3'b100;
  localparam logic [2:0] FUNCT3_MEM_HU = 3'b101;

  localparam int TIMEOUT_DEFAULT = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } lsu_state_e;

  // Stores only have B/H/W; loads add the unsigned B/H variants.
  function automatic logic op_legal(input logic wren, input logic [2:0] op);
    if (wren) return (op == FUNCT3_MEM_B) || (op == FUNCT3_MEM_H) || (op == FUNCT3_MEM_W);
    return (op == FUNCT3_MEM_B) || (op == FUNCT3_MEM_H) || (op == FUNCT3_MEM_W) ||
           (op == FUNCT3_MEM_BU) || (op == FUNCT3_MEM_HU);
  endfunction

  // op[1:0] encodes the access size for every legal funct3.
  function automatic logic op_aligned(input logic [2:0] op, input logic [1:0] off);
    case (op[1:0])
      2'b01:   return ~off[0];
      2'b10:   return (off == 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extraction plus sign/zero extension for loads.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        st_we_i,
  input  logic [2:0]  st_op_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic [2:0]  ld_op_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] rshift;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = st_data_i;
    if (st_we_i) begin
      case (st_op_i)
        FUNCT3_MEM_B: begin
          be_o    = 4'b0001 << st_off_i;
          wdata_o = {4{st_data_i[7:0]}};
        end
        FUNCT3_MEM_H: begin
          be_o    = 4'b0011 << st_off_i;
          wdata_o = {2{st_data_i[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rshift    = rdata_i >> {ld_off_i, 3'b000};
    ld_byte   = rshift[7:0];
    ld_half   = ld_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    ld_data_o = rdata_i;
    case (ld_op_i)
      FUNCT3_MEM_B:  ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      FUNCT3_MEM_BU: ld_data_o = {24'h000000, ld_byte};
      FUNCT3_MEM_H:  ld_data_o = {{16{ld_half[15]}}, ld_half};
      FUNCT3_MEM_HU: ld_data_o = {16'h0000, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: decodes memory ops, runs the req/gnt/rvalid bus handshake and
// stalls the core until the access commits.
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  input  logic        mem_wren_i,
  input  logic [2:0]  mem_op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] ld_data_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        access_fault_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [2:0]       op_q, op_d;
  logic [1:0]       off_q, off_d;
  logic [31:0]      ld_q, ld_d;
  logic             fault_q, fault_d;

  logic             legal, aligned, go;
  logic [3:0]       al_be;
  logic [31:0]      al_wdata, al_ld;

  lsu_align u_align (
    .st_we_i   (mem_wren_i),
    .st_op_i   (mem_op_i),
    .st_off_i  (addr_i[1:0]),
    .st_data_i (st_data_i),
    .be_o      (al_be),
    .wdata_o   (al_wdata),
    .ld_op_i   (op_q),
    .ld_off_i  (off_q),
    .rdata_i   (dmem_rdata_i),
    .ld_data_o (al_ld)
  );

  assign legal   = op_legal(mem_wren_i, mem_op_i);
  assign aligned = op_aligned(mem_op_i, addr_i[1:0]);
  assign go      = req_valid_i & legal & aligned;

  // Gated by reset so the core is released as soon as reset is applied.
  assign stall_o    = rst_ni & go & (state_q != ST_DONE);
  assign misalign_o = rst_ni & req_valid_i & legal & ~aligned & (state_q == ST_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    off_d   = off_q;
    ld_d    = ld_q;
    fault_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d = ST_REQ;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = mem_wren_i;
          addr_d  = {addr_i[31:2], 2'b00};
          be_d    = al_be;
          wdata_d = al_wdata;
          op_d    = mem_op_i;
          off_d   = addr_i[1:0];
        end
      end
      ST_REQ: begin
        if (dmem_gnt_i) begin
          req_d   = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A dropped req_valid_i means the core abandoned the access: finish it, keep ld_data.
        if (dmem_rvalid_i) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          if (!we_q && req_valid_i) ld_d = al_ld;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          fault_d = 1'b1;
          if (!we_q && req_valid_i) ld_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      op_q    <= '0;
      off_q   <= '0;
      ld_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      off_q   <= off_d;
      ld_q    <= ld_d;
      fault_q <= fault_d;
    end
  end

  assign ld_data_o      = ld_q;
  assign access_fault_o = fault_q;
  assign dmem_req_o     = req_q;
  assign dmem_we_o      = we_q;
  assign dmem_addr_o    = addr_q;
  assign dmem_be_o      = be_q;
  assign dmem_wdata_o   = wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: loads, stores, misalignment, illegal ops, timeout and reset mid-access.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        mem_wren;
  logic [2:0]  mem_op;
  logic [31:0] addr;
  logic [31:0] st_data;
  logic [31:0] ld_data_o;
  logic        stall_o, misalign_o, access_fault_o;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        gnt, rvalid;
  logic [31:0] rdata;

  int n_cmp = 0;
  int n_fail = 0;

  lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (req_valid),
    .mem_wren_i     (mem_wren),
    .mem_op_i       (mem_op),
    .addr_i         (addr),
    .st_data_i      (st_data),
    .ld_data_o      (ld_data_o),
    .stall_o        (stall_o),
    .misalign_o     (misalign_o),
    .access_fault_o (access_fault_o),
    .dmem_req_o     (dmem_req_o),
    .dmem_we_o      (dmem_we_o),
    .dmem_addr_o    (dmem_addr_o),
    .dmem_be_o      (dmem_be_o),
    .dmem_wdata_o   (dmem_wdata_o),
    .dmem_gnt_i     (gnt),
    .dmem_rvalid_i  (rvalid),
    .dmem_rdata_i   (rdata)
  );

  always #5 clk = ~clk;

  // Results of one access as seen by the bench's bus responder.
  int          r_stalls;
  bit          r_req_seen, r_hung;
  logic [3:0]  r_be;
  logic [31:0] r_addr, r_wdata, r_ld;
  logic        r_we, r_fault, r_mis;

  // Presents one instruction at posedge+1 and plays a bus that grants immediately and
  // answers one cycle after the grant (unless give_rv = 0). Returns in the cycle after commit.
  task automatic do_access(input logic wren, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] sd, input logic [31:0] rd, input bit give_rv);
    bit pend;
    req_valid = 1'b1; mem_wren = wren; mem_op = op; addr = a; st_data = sd; rdata = rd;
    gnt = 1'b0; rvalid = 1'b0; pend = 1'b0;
    r_stalls = 0; r_req_seen = 1'b0; r_hung = 1'b1;
    r_be = 'x; r_addr = 'x; r_wdata = 'x; r_we = 1'bx;
    #1;
    r_mis = misalign_o;
    for (int c = 0; c < 40; c++) begin
      if (!stall_o) begin
        r_hung = 1'b0;
        break;
      end
      r_stalls++;
      gnt = 1'b0; rvalid = 1'b0;
      if (dmem_req_o) begin
        gnt = 1'b1; r_req_seen = 1'b1; pend = give_rv;
        r_be = dmem_be_o; r_addr = dmem_addr_o; r_wdata = dmem_wdata_o; r_we = dmem_we_o;
      end else if (pend) begin
        rvalid = 1'b1; pend = 1'b0;
      end
      @(posedge clk); #1;
    end
    gnt = 1'b0; rvalid = 1'b0;
    r_fault = access_fault_o;
    r_ld    = ld_data_o;
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    req_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; mem_wren = 1'b0; mem_op = 3'b000; addr = '0;
    st_data = '0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({ld_data_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ld=%h req=%b we=%b addr=%h be=%b wd=%h, required all zero",
               ld_data_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o);
    end
    n_cmp++;
    if ({stall_o, misalign_o, access_fault_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got stall/mis/fault=%b, required 000",
               {stall_o, misalign_o, access_fault_o});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    do_access(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEADBEEF, 1'b1);
    n_cmp++;
    if (r_hung !== 1'b0 || r_stalls !== 3) begin
      n_fail++; $display("FAIL lw_stall_cycles: got %0d (hung=%b), required 3", r_stalls, r_hung);
    end
    n_cmp++;
    if (r_be !== 4'b1111 || r_addr !== 32'h100 || r_we !== 1'b0) begin
      n_fail++; $display("FAIL lw_bus: got be=%b addr=%h we=%b, required 1111 00000100 0", r_be, r_addr, r_we);
    end
    n_cmp++;
    if (r_ld !== 32'hDEADBEEF || r_fault !== 1'b0) begin
      n_fail++; $display("FAIL lw_data: got %h fault=%b, required deadbeef 0", r_ld, r_fault);
    end
    idle_cycle();
  endtask

  task automatic test_load_extend();
    do_access(1'b0, 3'b000, 32'h0000_0203, 32'h0, 32'h80FF7F01, 1'b1);
    n_cmp++;
    if (r_ld !== 32'hFFFFFF80 || r_addr !== 32'h200) begin
      n_fail++; $display("FAIL lb_sign: got ld=%h addr=%h, required ffffff80 00000200", r_ld, r_addr);
    end
    do_access(1'b0, 3'b100, 32'h0000_0203, 32'h0, 32'h80FF7F01, 1'b1);
    n_cmp++;
    if (r_ld !== 32'h00000080) begin
      n_fail++; $display("FAIL lbu_zero: got %h, required 00000080", r_ld);
    end
    do_access(1'b0, 3'b001, 32'h0000_0202, 32'h0, 32'h80FF7F01, 1'b1);
    n_cmp++;
    if (r_ld !== 32'hFFFF80FF) begin
      n_fail++; $display("FAIL lh_upper: got %h, required ffff80ff", r_ld);
    end
    do_access(1'b0, 3'b101, 32'h0000_0200, 32'h0, 32'h80FF7F01, 1'b1);
    n_cmp++;
    if (r_ld !== 32'h00007F01) begin
      n_fail++; $display("FAIL lhu_lower: got %h, required 00007f01", r_ld);
    end
    idle_cycle();
  endtask

  task automatic test_store();
    do_access(1'b1, 3'b001, 32'h0000_0302, 32'h1234ABCD, 32'h0, 1'b1);
    n_cmp++;
    if (r_be !== 4'b1100 || r_wdata !== 32'hABCDABCD || r_we !== 1'b1 || r_addr !== 32'h300) begin
      n_fail++; $display("FAIL sh_bus: got be=%b wd=%h we=%b addr=%h, required 1100 abcdabcd 1 00000300",
                         r_be, r_wdata, r_we, r_addr);
    end
    n_cmp++;
    if (r_ld !== 32'h00007F01 || r_stalls !== 3) begin
      n_fail++; $display("FAIL sh_ld_kept: got ld=%h stalls=%0d, required 00007f01 3", r_ld, r_stalls);
    end
    do_access(1'b1, 3'b000, 32'h0000_0101, 32'h11223355, 32'h0, 1'b1);
    n_cmp++;
    if (r_be !== 4'b0010 || r_wdata !== 32'h55555555) begin
      n_fail++; $display("FAIL sb_bus: got be=%b wd=%h, required 0010 55555555", r_be, r_wdata);
    end
    do_access(1'b1, 3'b010, 32'h0000_0104, 32'hCAFEF00D, 32'h0, 1'b1);
    n_cmp++;
    if (r_be !== 4'b1111 || r_wdata !== 32'hCAFEF00D || r_addr !== 32'h104) begin
      n_fail++; $display("FAIL sw_bus: got be=%b wd=%h addr=%h, required 1111 cafef00d 00000104", r_be, r_wdata, r_addr);
    end
    idle_cycle();
  endtask

  task automatic test_misalign_illegal();
    do_access(1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h0, 1'b1);
    n_cmp++;
    if (r_mis !== 1'b1 || r_stalls !== 0 || r_req_seen !== 1'b0) begin
      n_fail++; $display("FAIL lw_misalign: got mis=%b stalls=%0d req=%b, required 1 0 0", r_mis, r_stalls, r_req_seen);
    end
    do_access(1'b1, 3'b001, 32'h0000_0301, 32'h0, 32'h0, 1'b1);
    n_cmp++;
    if (r_mis !== 1'b1 || r_stalls !== 0 || r_req_seen !== 1'b0) begin
      n_fail++; $display("FAIL sh_misalign: got mis=%b stalls=%0d req=%b, required 1 0 0", r_mis, r_stalls, r_req_seen);
    end
    n_cmp++;
    if (dmem_req_o !== 1'b0 || misalign_o !== 1'b0 && req_valid === 1'b0) begin
      n_fail++; $display("FAIL misalign_no_bus: got req=%b, required 0", dmem_req_o);
    end
    do_access(1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'h0, 1'b1);
    n_cmp++;
    if (r_mis !== 1'b0 || r_stalls !== 0 || r_req_seen !== 1'b0 || r_ld !== 32'h00007F01) begin
      n_fail++; $display("FAIL ld_illegal: got mis=%b stalls=%0d req=%b ld=%h, required 0 0 0 00007f01",
                         r_mis, r_stalls, r_req_seen, r_ld);
    end
    do_access(1'b1, 3'b100, 32'h0000_0100, 32'h0, 32'h0, 1'b1);
    n_cmp++;
    if (r_mis !== 1'b0 || r_stalls !== 0 || r_req_seen !== 1'b0) begin
      n_fail++; $display("FAIL st_illegal: got mis=%b stalls=%0d req=%b, required 0 0 0", r_mis, r_stalls, r_req_seen);
    end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    do_access(1'b0, 3'b010, 32'h0000_0700, 32'h0, 32'hA5A5A5A5, 1'b1);
    n_cmp++;
    if (r_ld !== 32'hA5A5A5A5 || r_stalls !== 3) begin
      n_fail++; $display("FAIL b2b_first: got ld=%h stalls=%0d, required a5a5a5a5 3", r_ld, r_stalls);
    end
    do_access(1'b0, 3'b001, 32'h0000_0702, 32'h0, 32'h80010000, 1'b1);
    n_cmp++;
    if (r_ld !== 32'hFFFF8001 || r_stalls !== 3 || r_addr !== 32'h700) begin
      n_fail++; $display("FAIL b2b_second: got ld=%h stalls=%0d addr=%h, required ffff8001 3 00000700",
                         r_ld, r_stalls, r_addr);
    end
    idle_cycle();
  endtask

  task automatic test_timeout();
    do_access(1'b0, 3'b010, 32'h0000_0400, 32'h0, 32'h12345678, 1'b0);
    n_cmp++;
    if (r_hung !== 1'b0 || r_stalls !== 6) begin
      n_fail++; $display("FAIL timeout_stalls: got %0d (hung=%b), required 6", r_stalls, r_hung);
    end
    n_cmp++;
    if (r_fault !== 1'b1 || r_ld !== 32'h0) begin
      n_fail++; $display("FAIL timeout_fault: got fault=%b ld=%h, required 1 00000000", r_fault, r_ld);
    end
    n_cmp++;
    if (access_fault_o !== 1'b0 || dmem_req_o !== 1'b0) begin
      n_fail++; $display("FAIL timeout_pulse: got fault=%b req=%b after commit, required 0 0", access_fault_o, dmem_req_o);
    end
    idle_cycle();
  endtask

  task automatic test_reset_in_wait();
    do_access(1'b0, 3'b010, 32'h0000_0104, 32'h0, 32'h0BADF00D, 1'b1);
    req_valid = 1'b1; mem_wren = 1'b0; mem_op = 3'b010; addr = 32'h500; rdata = 32'h0;
    @(posedge clk); #1;
    gnt = 1'b1;
    @(posedge clk); #1;
    gnt = 1'b0;
    n_cmp++;
    if (stall_o !== 1'b1 || dmem_req_o !== 1'b0) begin
      n_fail++; $display("FAIL wait_entered: got stall=%b req=%b, required 1 0", stall_o, dmem_req_o);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (stall_o !== 1'b0 || dmem_req_o !== 1'b0 || ld_data_o !== 32'h0 || dmem_addr_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_in_wait: got stall=%b req=%b ld=%h addr=%h, required 0 0 00000000 00000000",
                         stall_o, dmem_req_o, ld_data_o, dmem_addr_o);
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_access(1'b0, 3'b010, 32'h0000_0600, 32'h0, 32'h13579BDF, 1'b1);
    n_cmp++;
    if (r_ld !== 32'h13579BDF || r_stalls !== 3 || r_addr !== 32'h600) begin
      n_fail++; $display("FAIL after_reset_lw: got ld=%h stalls=%0d addr=%h, required 13579bdf 3 00000600",
                         r_ld, r_stalls, r_addr);
    end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_extend();
    test_store();
    test_misalign_illegal();
    test_back_to_back();
    test_timeout();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
